// File: rtl/hand_fifo_wr_arbiter.sv
// Round-robin write-port arbiter placed in front of hand_fifo; NUM_REQ valid/ready producers share one FIFO.
// Latency: zero; the granted word passes combinationally to the FIFO. One IDLE bubble separates grants.
// Backpressure: i_fifo_ready=0 stalls the granted requester, which keeps the grant and its burst count.
//
// Ports:
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_req_valid/_data     per-requester word valid and data (requester i at [i*WIDTH +: WIDTH])
//   o_req_ready           per-requester accept, one-hot or zero
//   i_fifo_ready          FIFO not full
//   o_fifo_wr_en/_data    FIFO write strobe and data
//   o_grant_id            index of the current (or most recent) grant
//   o_busy                high while a grant is active
module hand_fifo_wr_arbiter #(
  parameter int WIDTH     = 8,
  parameter int NUM_REQ   = 4,
  parameter int MAX_BURST = 4
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic [NUM_REQ-1:0]         i_req_valid,
  input  logic [NUM_REQ*WIDTH-1:0]   i_req_data,
  output logic [NUM_REQ-1:0]         o_req_ready,
  input  logic                       i_fifo_ready,
  output logic                       o_fifo_wr_en,
  output logic [WIDTH-1:0]           o_fifo_wr_data,
  output logic [$clog2(NUM_REQ)-1:0] o_grant_id,
  output logic                       o_busy
);

  localparam int IDW = $clog2(NUM_REQ);
  localparam int BCW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [IDW-1:0] LAST_ID   = IDW'(NUM_REQ - 1);
  localparam logic [BCW-1:0] LAST_BEAT = BCW'(MAX_BURST - 1);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } state_t;

  state_t         r_state,     w_state_nxt;
  logic [IDW-1:0] r_grant_id,  w_grant_id_nxt;
  logic [IDW-1:0] r_rr_ptr,    w_rr_ptr_nxt;
  logic [BCW-1:0] r_burst_cnt, w_burst_cnt_nxt;

  logic [IDW-1:0]   w_winner;
  logic             w_any_req;
  logic [IDW-1:0]   w_ptr_after_grant;
  logic             w_sel_valid;
  logic [WIDTH-1:0] w_sel_data;

  // Scan requesters starting at r_rr_ptr, wrapping explicitly so that
  // non-power-of-two NUM_REQ never visits an out-of-range index.
  always_comb begin
    logic [IDW-1:0] idx;
    w_winner  = r_rr_ptr;
    w_any_req = 1'b0;
    idx       = r_rr_ptr;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!w_any_req && i_req_valid[idx]) begin
        w_any_req = 1'b1;
        w_winner  = idx;
      end
      idx = (idx == LAST_ID) ? '0 : idx + IDW'(1);
    end
  end

  assign w_ptr_after_grant = (r_grant_id == LAST_ID) ? '0 : r_grant_id + IDW'(1);
  assign w_sel_valid       = i_req_valid[r_grant_id];
  assign w_sel_data        = i_req_data[r_grant_id*WIDTH +: WIDTH];

  // Outputs are forced quiet while reset is asserted so the word presented
  // on the reset cycle is never written.
  always_comb begin
    o_req_ready    = '0;
    o_fifo_wr_en   = 1'b0;
    o_fifo_wr_data = '0;
    o_busy         = 1'b0;
    if (!i_rst && (r_state == S_GRANT)) begin
      o_busy                  = 1'b1;
      o_req_ready[r_grant_id] = i_fifo_ready;
      o_fifo_wr_en            = w_sel_valid & i_fifo_ready;
      o_fifo_wr_data          = w_sel_data;
    end
  end

  assign o_grant_id = r_grant_id;

  always_comb begin
    w_state_nxt     = r_state;
    w_grant_id_nxt  = r_grant_id;
    w_rr_ptr_nxt    = r_rr_ptr;
    w_burst_cnt_nxt = r_burst_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_any_req) begin
          w_state_nxt     = S_GRANT;
          w_grant_id_nxt  = w_winner;
          w_burst_cnt_nxt = '0;
        end
      end
      S_GRANT: begin
        if (!w_sel_valid) begin
          // Requester yielded: release without a transfer.
          w_state_nxt  = S_IDLE;
          w_rr_ptr_nxt = w_ptr_after_grant;
        end else if (i_fifo_ready) begin
          if (r_burst_cnt == LAST_BEAT) begin
            w_state_nxt  = S_IDLE;
            w_rr_ptr_nxt = w_ptr_after_grant;
          end else begin
            w_burst_cnt_nxt = r_burst_cnt + BCW'(1);
          end
        end
        // valid with FIFO full: hold everything.
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_grant_id  <= '0;
      r_rr_ptr    <= '0;
      r_burst_cnt <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_grant_id  <= w_grant_id_nxt;
      r_rr_ptr    <= w_rr_ptr_nxt;
      r_burst_cnt <= w_burst_cnt_nxt;
    end
  end

endmodule
